// File: rtl/dvi_in_frame_ctrl_if.sv
// Bundle of video input, capture request and measurement/capture outputs
// for dvi_in_frame_ctrl.
// slave  : frame controller side (video in, status/capture out)
// master : source/consumer side (video out, status/capture in)
interface dvi_in_frame_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             ce;
    logic             de;
    logic             vsync;
    logic             hsync;
    logic             cap_req;
    logic             locked;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_active;
    logic             cap_busy;
    logic             frame_start;
    logic             cap_de;
    logic             cap_done;
    logic             cap_err;

    modport master (
        output ce, de, vsync, hsync, cap_req,
        input  locked, h_total, h_active, v_total, v_active,
        input  cap_busy, frame_start, cap_de, cap_done, cap_err
    );

    modport slave (
        input  ce, de, vsync, hsync, cap_req,
        output locked, h_total, h_active, v_total, v_active,
        output cap_busy, frame_start, cap_de, cap_done, cap_err
    );
endinterface

// File: rtl/dvi_in_frame_ctrl.sv
// Measures input video timing, declares lock on stable frames and gates a
// single whole-frame capture window between two vsync edges.
// Ports: clk, rst (sync, active-high), bus (slave): ce/de/vsync/hsync/cap_req
// in; locked, h/v totals and actives, cap_busy/frame_start/cap_de/cap_done/
// cap_err out, all registered.
module dvi_in_frame_ctrl #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2,
    parameter bit VS_POL      = 1'b1,
    parameter bit HS_POL      = 1'b1
) (
    input logic               clk,
    input logic               rst,
    dvi_in_frame_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LF  = 4'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    logic             vs_n, hs_n;
    logic             vs_prev, hs_prev, de_prev;
    logic             ve, he, dr;

    logic [CNT_W-1:0] lp_cnt, lp_lat, de_cnt, wd_lat, ln_cnt, dr_cnt;
    logic [CNT_W-1:0] lp_nx, lat_nx, de_nx, wd_nx;
    logic [CNT_W-1:0] ln_inc, dr_inc, ln_nx, dr_nx;
    logic [CNT_W-1:0] h_tot, h_act, v_tot, v_act;

    logic [3:0]       stable, stab_nx;
    logic             seen_ve;
    logic             same, any_sat;
    logic             locked_q, lock_nx;

    state_t           state;
    logic             busy, fstart, cde, cdone, cerr;

    assign vs_n = bus.vsync ~^ VS_POL;
    assign hs_n = bus.hsync ~^ HS_POL;

    assign ve = bus.ce & vs_n & ~vs_prev;
    assign he = bus.ce & hs_n & ~hs_prev;
    assign dr = bus.ce & bus.de & ~de_prev;

    // Next-state values; the VE publish uses them so an HE/DR landing on the
    // VE cycle still belongs to the frame that is ending.
    assign lp_nx  = he ? ONE : (bus.ce ? sat_inc(lp_cnt) : lp_cnt);
    assign lat_nx = he ? lp_cnt : lp_lat;
    assign de_nx  = he ? '0 : ((bus.ce & bus.de) ? sat_inc(de_cnt) : de_cnt);
    assign wd_nx  = (he && de_cnt != '0) ? de_cnt : wd_lat;
    assign ln_inc = he ? sat_inc(ln_cnt) : ln_cnt;
    assign dr_inc = dr ? sat_inc(dr_cnt) : dr_cnt;
    assign ln_nx  = ve ? '0 : ln_inc;
    assign dr_nx  = ve ? '0 : dr_inc;

    assign same = (lat_nx == h_tot) && (wd_nx == h_act) &&
                  (ln_inc == v_tot) && (dr_inc == v_act);
    assign any_sat = (lat_nx == MAX) || (wd_nx == MAX) ||
                     (ln_inc == MAX) || (dr_inc == MAX);

    always_comb begin
        stab_nx = stable;
        if (ve) begin
            if (seen_ve && same && !any_sat)
                stab_nx = (stable == LF) ? LF : stable + 4'd1;
            else
                stab_nx = '0;
        end
        // A runaway line or frame means the source is gone: drop lock now.
        if (lp_nx == MAX || ln_nx == MAX)
            stab_nx = '0;
    end

    assign lock_nx = (stab_nx == LF);

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev  <= 1'b0;
            hs_prev  <= 1'b0;
            de_prev  <= 1'b0;
            lp_cnt   <= '0;
            lp_lat   <= '0;
            de_cnt   <= '0;
            wd_lat   <= '0;
            ln_cnt   <= '0;
            dr_cnt   <= '0;
            h_tot    <= '0;
            h_act    <= '0;
            v_tot    <= '0;
            v_act    <= '0;
            stable   <= '0;
            seen_ve  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            if (bus.ce) begin
                vs_prev <= vs_n;
                hs_prev <= hs_n;
                de_prev <= bus.de;
            end
            lp_cnt <= lp_nx;
            lp_lat <= lat_nx;
            de_cnt <= de_nx;
            wd_lat <= wd_nx;
            ln_cnt <= ln_nx;
            dr_cnt <= dr_nx;
            if (ve) begin
                h_tot   <= lat_nx;
                h_act   <= wd_nx;
                v_tot   <= ln_inc;
                v_act   <= dr_inc;
                seen_ve <= 1'b1;
            end
            stable   <= stab_nx;
            locked_q <= lock_nx;
        end
    end

    // Loss of lock wins over a coincident VE so a bad frame never
    // reports cap_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            fstart <= 1'b0;
            cde    <= 1'b0;
            cdone  <= 1'b0;
            cerr   <= 1'b0;
        end else begin
            fstart <= 1'b0;
            cde    <= 1'b0;
            cdone  <= 1'b0;
            cerr   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cap_req && locked_q) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!lock_nx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cerr  <= 1'b1;
                    end else if (ve) begin
                        state  <= CAPTURE;
                        fstart <= 1'b1;
                        cde    <= bus.de & bus.ce;
                    end
                end
                CAPTURE: begin
                    if (!lock_nx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cerr  <= 1'b1;
                    end else if (ve) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cdone <= 1'b1;
                    end else begin
                        cde <= bus.de & bus.ce;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked      = locked_q;
    assign bus.h_total     = h_tot;
    assign bus.h_active    = h_act;
    assign bus.v_total     = v_tot;
    assign bus.v_active    = v_act;
    assign bus.cap_busy    = busy;
    assign bus.frame_start = fstart;
    assign bus.cap_de      = cde;
    assign bus.cap_done    = cdone;
    assign bus.cap_err     = cerr;

endmodule

// File: tb/tb_dvi_in_frame_ctrl.sv
// Directed bench for dvi_in_frame_ctrl: two instances (active-high and
// active-low syncs) share one stimulus and one expected-value queue.
module tb_dvi_in_frame_ctrl;

    localparam int W    = 8;
    localparam int LF   = 2;
    localparam int HT   = 24;
    localparam int HT2  = 26;
    localparam int HA   = 16;
    localparam int VT   = 14;
    localparam int VA   = 10;
    localparam int MAXI = 2**W - 1;
    localparam logic [W-1:0] MAXV = '1;

    typedef struct packed {
        logic [5:0]     ctl;
        logic           pub_chk;
        logic [4*W-1:0] pub;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ce, de, vs, hs, req;

    always #5 clk = ~clk;

    dvi_in_frame_ctrl_if #(.CNT_W(W)) bus_a ();
    dvi_in_frame_ctrl_if #(.CNT_W(W)) bus_b ();

    assign bus_a.ce      = ce;
    assign bus_a.de      = de;
    assign bus_a.vsync   = vs;
    assign bus_a.hsync   = hs;
    assign bus_a.cap_req = req;
    assign bus_b.ce      = ce;
    assign bus_b.de      = de;
    assign bus_b.vsync   = ~vs;
    assign bus_b.hsync   = ~hs;
    assign bus_b.cap_req = req;

    dvi_in_frame_ctrl #(
        .CNT_W(W), .LOCK_FRAMES(LF), .VS_POL(1'b1), .HS_POL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    dvi_in_frame_ctrl #(
        .CNT_W(W), .LOCK_FRAMES(LF), .VS_POL(1'b0), .HS_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cap_cnt = 0;
    bit   cnt_en = 0;

    // reference model state
    int             m_stable, m_st, m_lines;
    bit             m_locked, m_seen, m_pub_ok;
    logic [4*W-1:0] m_pub;
    int             g_ht;
    bit             g_ok;

    function automatic bit has_sat(input logic [4*W-1:0] t);
        for (int i = 0; i < 4; i++)
            if (t[i*W +: W] == MAXV) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare();
        exp_t e;
        logic [5:0] ca, cb;
        logic [4*W-1:0] pa, pb;
        if (q.size() == 0) return;
        e  = q.pop_front();
        ca = {bus_a.locked, bus_a.cap_busy, bus_a.frame_start,
              bus_a.cap_done, bus_a.cap_err, bus_a.cap_de};
        cb = {bus_b.locked, bus_b.cap_busy, bus_b.frame_start,
              bus_b.cap_done, bus_b.cap_err, bus_b.cap_de};
        pa = {bus_a.h_total, bus_a.h_active, bus_a.v_total, bus_a.v_active};
        pb = {bus_b.h_total, bus_b.h_active, bus_b.v_total, bus_b.v_active};
        if (cnt_en && bus_a.cap_de) cap_cnt++;
        checks++;
        assert (ca === e.ctl) else begin
            failures++;
            $error("FAIL ctl_a t=%0t got=%b exp=%b", $time, ca, e.ctl);
        end
        checks++;
        assert (cb === e.ctl) else begin
            failures++;
            $error("FAIL ctl_b t=%0t got=%b exp=%b", $time, cb, e.ctl);
        end
        if (e.pub_chk) begin
            checks++;
            assert (pa === e.pub) else begin
                failures++;
                $error("FAIL pub_a t=%0t got=%h exp=%h", $time, pa, e.pub);
            end
            checks++;
            assert (pb === e.pub) else begin
                failures++;
                $error("FAIL pub_b t=%0t got=%h exp=%h", $time, pb, e.pub);
            end
        end
    endtask

    // One clk of stimulus: check the previous cycle's outputs, drive, then
    // push what the DUTs must show after the coming edge.
    task automatic step(input bit r, input bit c, input bit d, input bit v,
                        input bit h, input bit rq, input bit ve_ev,
                        input bit he_ev, input bit k,
                        input logic [4*W-1:0] t);
        exp_t e;
        bit old_lk, fs, dn, er, cd;
        @(negedge clk);
        compare();
        rst = r; ce = c; de = d; vs = v; hs = h; req = rq;
        fs = 0; dn = 0; er = 0; cd = 0;
        if (r) begin
            m_stable = 0; m_st = 0; m_lines = 0;
            m_locked = 0; m_seen = 0; m_pub_ok = 1; m_pub = '0;
        end else begin
            old_lk = m_locked;
            if (ve_ev) begin
                if (!m_seen || !k || !m_pub_ok || t != m_pub || has_sat(t))
                    m_stable = 0;
                else if (m_stable < LF)
                    m_stable++;
                m_pub = t; m_pub_ok = k; m_seen = 1; m_lines = 0;
            end else if (he_ev && m_lines < MAXI) begin
                m_lines++;
            end
            if (m_lines == MAXI) m_stable = 0;
            m_locked = (m_stable == LF);
            case (m_st)
                0: if (rq && old_lk) m_st = 1;
                1: if (!m_locked) begin m_st = 0; er = 1; end
                   else if (ve_ev) begin m_st = 2; fs = 1; cd = d & c; end
                default: if (!m_locked) begin m_st = 0; er = 1; end
                   else if (ve_ev) begin m_st = 0; dn = 1; end
                   else cd = d & c;
            endcase
        end
        e.ctl     = {m_locked, (m_st != 0), fs, dn, er, cd};
        e.pub_chk = m_pub_ok;
        e.pub     = m_pub;
        q.push_back(e);
    endtask

    task automatic reset_for(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        g_ok = 0;
    endtask

    task automatic frame(input int ht, input bit tog, input int req_line,
                         input int rst_line);
        logic [4*W-1:0] t;
        bit k, d, v, h, r;
        k = g_ok;
        t = {W'(g_ht), W'(HA), W'(VT), W'(VA)};
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < ht; x++) begin
                if (y == rst_line && x == 0) begin
                    reset_for(3);
                    return;
                end
                d = (y >= 2 && y < 2 + VA && x >= 4 && x < 4 + HA);
                v = (y < 2);
                h = (x < 2);
                r = (y == req_line && x == 5);
                step(0, 1, d, v, h, r, (x == 0 && y == 0), (x == 0), k, t);
                if (tog) step(0, 0, ~d, ~v, ~h, 0, 0, 0, k, t);
            end
        end
        g_ht = ht;
        g_ok = 1;
    endtask

    task automatic lines_no_vs(input int ht, input int n, input int req_line);
        for (int y = 0; y < n; y++)
            for (int x = 0; x < ht; x++)
                step(0, 1, 0, 0, (x < 2), (y == req_line && x == 5),
                     0, (x == 0), 0, '0);
        g_ok = 0;
    endtask

    initial begin
        rst = 1; ce = 0; de = 0; vs = 0; hs = 0; req = 0;
        m_stable = 0; m_st = 0; m_lines = 0;
        m_locked = 0; m_seen = 0; m_pub_ok = 1; m_pub = '0;
        g_ht = 0; g_ok = 0;

        reset_for(3);

        // stable timing, ce=1: measurement and lock
        repeat (4) frame(HT, 0, -1, -1);

        // one full capture; a second request mid-capture is dropped
        cnt_en = 1;
        frame(HT, 0, 3, -1);
        frame(HT, 0, 5, -1);
        frame(HT, 0, -1, -1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        cnt_en = 0;
        checks++;
        assert (cap_cnt === HA * VA) else begin
            failures++;
            $error("FAIL cap_count got=%0d exp=%0d", cap_cnt, HA * VA);
        end

        // line length changes during capture: abort, then relock
        frame(HT, 0, 3, -1);
        repeat (4) frame(HT2, 0, -1, -1);

        // vsync lost: line counter saturates, request while unlocked
        lines_no_vs(HT2, 260, 250);

        // ce toggling with garbage on ce=0 cycles, then reset mid-capture
        reset_for(3);
        repeat (3) frame(HT, 1, -1, -1);
        frame(HT, 1, 3, -1);
        frame(HT, 1, -1, 5);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        @(negedge clk);
        compare();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvi_in_frame_ctrl.md
# dvi_in_frame_ctrl

Frame controller for the registered DVI/DP input video stream. It measures incoming timing and declares lock when that timing is stable across frames. On request it sequences a single whole-frame capture window for the downstream frame-buffer writer, gating the write strobe to exactly one complete frame, starting and ending on vsync boundaries.

## Interface
Parameters:
- CNT_W, 12, width of all timing counters and measurement outputs
- LOCK_FRAMES, 2, consecutive matching frame measurements required before `locked` asserts (1..15)
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low)
- HS_POL, 1, hsync active level

Ports:
- clk  in  1  pixel-domain clock; the only clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel qualifier; all video-side logic advances only on clk cycles with ce=1
- de  in  1  data enable from the input register stage
- vsync  in  1  vertical sync, level per VS_POL
- hsync  in  1  horizontal sync, level per HS_POL
- cap_req  in  1  capture request, sampled in IDLE only
- locked  out  1  timing stable
- h_total  out  CNT_W  ce-cycles per line
- h_active  out  CNT_W  de ce-cycles in last active line
- v_total  out  CNT_W  lines per frame
- v_active  out  CNT_W  lines containing de per frame
- cap_busy  out  1  capture FSM not IDLE
- frame_start  out  1  one-clk pulse, capture frame begins
- cap_de  out  1  write strobe for the captured frame
- cap_done  out  1  one-clk pulse, capture completed
- cap_err  out  1  one-clk pulse, capture aborted

## Operation
- Sync normalisation: vs_n = vsync XNOR VS_POL, hs_n likewise. Previous-sample registers update only when ce=1.
- Edge events, valid only in ce=1 cycles: VE = vs_n & ~vs_prev; HE = hs_n & ~hs_prev; DR = de & ~de_prev.
- Line-period counter: set to 1 on HE; otherwise +1 per ce. On HE, its previous value is latched as the line period.
- de counter: cleared on HE; +1 per ce&de. On HE, a nonzero value is latched as the active width.
- Line counter: +1 per HE. v_active counter: +1 per DR. Both clear on VE. An HE coincident with VE counts toward the ending frame.
- All counters saturate at 2^CNT_W−1.
- On VE, publish {latched line period, latched width, line count, DR count} to {h_total, h_active, v_total, v_active}.
- Lock tracking on VE:
  - If all four published values equal the previous published values and none is saturated: stable_cnt = min(stable_cnt+1, LOCK_FRAMES).
  - Otherwise stable_cnt = 0.
  - locked = (stable_cnt == LOCK_FRAMES).
- Loss of lock: if the line-period or line counter reaches saturation, stable_cnt and locked clear immediately (no VE needed).
- The first VE after reset always counts as a mismatch.
- Capture FSM states and transitions:
  - IDLE: cap_req & locked → ARMED. cap_req while not IDLE, or while unlocked, is ignored (no queuing).
  - ARMED: VE → CAPTURE; pulse frame_start.
  - CAPTURE: cap_de = de & ce. Next VE → IDLE; pulse cap_done.
  - ARMED or CAPTURE with locked falling → IDLE; pulse cap_err, no cap_done. This takes priority over a coincident VE.
- cap_busy = (state != IDLE).

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE, stable_cnt 0, all counters and prev registers 0.
- A VE detected on clk edge n makes published values, locked, frame_start and cap_done visible after edge n+1.
- cap_de has 1-clk latency relative to de/ce. Downstream must delay pixel data by one register to align.
- A capture started by VE has its first cap_de candidate in that same VE ce-cycle; it appears on cap_de at n+1.
- The terminating VE cycle is excluded from the capture.
- rst asserted mid-capture: all outputs are 0 after the next clk edge, with no cap_done and no cap_err.

## Test plan
- 800×525 timing (640×480 active), ce=1, LOCK_FRAMES=2 → locked rises 1 clk after the 3rd VE; h_total=800, h_active=640, v_total=525, v_active=480.
- Same timing with ce toggling every clk → identical values; locked after 3rd VE; no counting in ce=0 cycles.
- Locked, pulse cap_req → cap_busy next clk; frame_start 1 clk after next VE; exactly 307200 cap_de cycles; one cap_done; cap_busy=0 after.
- Mid-capture, line length changes to 810 → locked=0 and cap_err one pulse after next VE; no cap_done; h_total=810; relock after two further frames.
- vsync held inactive → line counter hits 4095 → locked=0 next clk; cap_req ignored, cap_busy stays 0.
- VS_POL=HS_POL=0 with inverted syncs → same results as the first scenario; rst pulse during CAPTURE → all outputs 0 next clk.
